// File: rtl/fu_commit_arbiter.sv
// Execute-to-commit result buffering: one circular queue per FU source,
// up to NUM_PORT heads granted per cycle. COMMIT_ARB_RR_EN selects round-robin.
module fu_commit_arbiter #(
  parameter int NUM_SRC  = 4,
  parameter int NUM_PORT = 2,
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 64,
  parameter int SRC_W    = $clog2(NUM_SRC)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [NUM_SRC-1:0]             src_valid,
  output logic [NUM_SRC-1:0]             src_ready,
  input  logic [NUM_SRC*DATA_W-1:0]      src_data,
  output logic [NUM_PORT-1:0]            port_valid,
  input  logic [NUM_PORT-1:0]            port_ready,
  output logic [NUM_PORT*DATA_W-1:0]     port_data,
  output logic [NUM_PORT*SRC_W-1:0]      port_src,
  output logic [NUM_SRC*($clog2(DEPTH)+1)-1:0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_XOR = {1'b1, {AW{1'b0}}};

  logic [PW-1:0]     head    [NUM_SRC];
  logic [PW-1:0]     tail    [NUM_SRC];
  logic [AW-1:0]     hd_addr [NUM_SRC];
  logic [AW-1:0]     tl_addr [NUM_SRC];
  logic [DATA_W-1:0] mem     [NUM_SRC][DEPTH];

  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;

  logic [NUM_PORT-1:0]            gnt_vld;
  logic [NUM_PORT-1:0][SRC_W-1:0] gnt_src;
  logic [NUM_PORT-1:0]            fire;
  logic [SRC_W-1:0]               rr_ptr;

  logic clr;

  assign clr = reset | flush;

  always_comb begin
    empty     = '0;
    full      = '0;
    push      = '0;
    occupancy = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hd_addr[i] = head[i][AW-1:0];
      tl_addr[i] = tail[i][AW-1:0];
      empty[i]   = head[i] == tail[i];
      full[i]    = (head[i] ^ tail[i]) == FULL_XOR;
      push[i]    = src_valid[i] & ~full[i];
      occupancy[i*PW +: PW] = tail[i] - head[i];
    end
  end

  assign src_ready = ~full;

  // Walk sources in priority order, compacting non-empty ones onto ports.
  always_comb begin
    int cnt;
    int idx;
    cnt     = 0;
    idx     = 0;
    gnt_vld = '0;
    gnt_src = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (i == idx && !empty[i]) begin
          for (int j = 0; j < NUM_PORT; j++) begin
            if (j == cnt) begin
              gnt_vld[j] = 1'b1;
              gnt_src[j] = SRC_W'(i);
            end
          end
          cnt = cnt + 1;
        end
      end
    end
  end

  always_comb begin
    port_valid = gnt_vld;
    port_data  = '0;
    port_src   = '0;
    for (int j = 0; j < NUM_PORT; j++) begin
      if (gnt_vld[j]) begin
        port_data[j*DATA_W +: DATA_W] =
          mem[gnt_src[j]][hd_addr[gnt_src[j]]];
        port_src[j*SRC_W +: SRC_W] = gnt_src[j];
      end
    end
  end

  assign fire = gnt_vld & port_ready;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int j = 0; j < NUM_PORT; j++) begin
        if (fire[j] && gnt_src[j] == SRC_W'(i)) pop[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (clr) begin
        head[i] <= '0;
        tail[i] <= '0;
      end else begin
        if (push[i]) tail[i] <= tail[i] + PW'(1);
        if (pop[i])  head[i] <= head[i] + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i] && !clr)
        mem[i][tl_addr[i]] <= src_data[i*DATA_W +: DATA_W];
    end
  end

`ifdef COMMIT_ARB_RR_EN
  logic [SRC_W-1:0] rr_nxt;

  // Highest-numbered popping port wins, so later ports override earlier.
  always_comb begin
    rr_nxt = rr_ptr;
    for (int j = 0; j < NUM_PORT; j++) begin
      if (fire[j]) begin
        rr_nxt = (gnt_src[j] == SRC_W'(NUM_SRC - 1)) ?
                 '0 : gnt_src[j] + SRC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) rr_ptr <= '0;
    else     rr_ptr <= rr_nxt;
  end
`else
  assign rr_ptr = '0;
`endif

endmodule

// File: doc/fu_commit_arbiter.md
# fu_commit_arbiter

Parametrised result-buffering and commit-port arbiter between the functional units of the execute stage and the commit stage. Each functional-unit result channel writes into its own circular queue. Every cycle, up to NUM_PORT queue heads are granted to the commit ports, with either fixed or round-robin priority. It generalises the single AGU commit queue and the hard-wired commit-bus muxing into N sources, K ports and configurable depth, with per-port backpressure.

## Interface
Parameters:
- NUM_SRC, default 4: number of functional-unit result sources, at least 2.
- NUM_PORT, default 2: number of commit ports, 1 ≤ NUM_PORT ≤ NUM_SRC.
- DEPTH, default 4: entries per source queue; must be a power of 2, at least 2.
- DATA_W, default 64: width of one flattened execute-to-commit record.
- SRC_W, default $clog2(NUM_SRC): width of a source-id field.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- flush  in  1  pipeline flush, synchronous; discards all buffered results.
- src_valid  in  NUM_SRC  per-source push request.
- src_ready  out  NUM_SRC  per-source queue has space.
- src_data  in  NUM_SRC*DATA_W  push records; source i occupies bits [i*DATA_W +: DATA_W].
- port_valid  out  NUM_PORT  commit port carries a record.
- port_ready  in  NUM_PORT  commit stage accepts the record on this port.
- port_data  out  NUM_PORT*DATA_W  records, packed the same way as src_data.
- port_src  out  NUM_PORT*SRC_W  source id driving each port.
- occupancy  out  NUM_SRC*($clog2(DEPTH)+1)  per-queue entry count.

## Operation
- Each source has a circular queue with head and tail pointers of $clog2(DEPTH)+1 bits.
  - Empty: head == tail.
  - Full: pointers differ only in the MSB.
  - Wrap-around is natural modulo-2·DEPTH pointer arithmetic.
- src_ready[i] = !full[i]. It depends only on registered state; there is no combinational path from port_ready.
- Push: src_valid[i] && src_ready[i] writes src_data[i] at the tail and increments tail. At most one push per source per cycle.
- Grant:
  - Build a priority-ordered list of non-empty sources.
  - The first NUM_PORT entries map, in order, to ports 0..NUM_PORT-1. Ports are compacted: port j is valid only if at least j+1 sources are non-empty.
  - A source is granted to at most one port per cycle.
- Port outputs: port_data[j] is the head record of the granted source and port_src[j] is that source's id. When port_valid[j]=0, both port_data[j] and port_src[j] are 0.
- Pop: port_valid[j] && port_ready[j] increments the head of the granted source. Ports handshake independently; a stall on port 0 does not block port 1.
- A simultaneous push and pop on the same queue leaves its count unchanged.
- Fixed priority (macro undefined): lower source index has higher priority.
- flush or reset:
  - All heads and tails go to 0.
  - The round-robin pointer goes to 0.
  - Any push or pop in the same cycle is ignored; flush dominates.

## Timing
- Latency: a record pushed in cycle t is visible on a port no earlier than t+1. There is no bypass from src_data to port_data.
- Throughput: 1 push per source per cycle; NUM_PORT pops per cycle in total.
- Reset values: port_valid=0, port_data=0, port_src=0, occupancy=0, src_ready all 1 (from the cycle after reset is asserted).
- A full queue deasserts src_ready in the same cycle its count reaches DEPTH. It reasserts in the cycle after a pop lowers the count, because src_ready is registered-state based.
- port_valid, port_data and port_src are combinational from queue state and the priority pointer only. They are stable within a cycle regardless of port_ready.
- The cycle after flush, all port_valid=0 and all src_ready=1.

## Configuration
- COMMIT_ARB_RR_EN defined: round-robin priority.
  - A pointer of SRC_W bits, reset to 0, marks the highest-priority source; priority descends cyclically from it.
  - After any cycle with at least one pop, the pointer becomes (port_src of the highest-numbered port that popped + 1) mod NUM_SRC.
  - If no pop occurs, the pointer holds.
- COMMIT_ARB_RR_EN undefined: fixed priority, source 0 highest. The pointer logic is absent.

## Test plan
- Defaults, all port_ready=1. Push sources 0, 1 and 2 in the same cycle -> next cycle, port 0 carries source 0 and port 1 carries source 1. The cycle after that, port 0 carries source 2 and port_valid[1]=0.
- port_ready=0. Push 4 records into source 3 -> src_ready[3]=0 after the 4th push and occupancy[3]=4. Raise port_ready[0] -> the records pop in push order and src_ready[3] returns to 1.
- Push 9 records through source 1 with random port_ready -> all 9 emerge in order with no loss or duplication (pointer wrap check).
- Fill sources 0 and 1 with 2 records each, then assert flush together with a push on source 2 -> next cycle, occupancy is all 0, port_valid=0 and the source-2 push is absent.
- port_ready=2'b10 with sources 0 and 1 non-empty -> only source 1 pops; source 0 holds on port 0.
- With COMMIT_ARB_RR_EN, keep all 4 sources continuously non-empty and NUM_PORT=2 -> grant pairs (0,1), (2,3), (0,1) on successive cycles. Without the macro -> (0,1) is granted every cycle.
